updown_dir_ctrl: RTL and testbench
==================================

Name: updown_dir_ctrl

Overview:
Input conditioner that sits directly upstream of the 3-bit up/down counter. It synchronises and debounces a raw push-button and produces the counter's direction input (dir drives x). It also provides a debounced level and a single-cycle press pulse for other consumers. In toggle mode, each accepted press flips direction.

Parameters:
DB_MAX, 4, consecutive stable cycles required to accept a level change; legal range 2..255
TOGGLE_MODE, 1, 1 = each accepted press toggles dir; 0 = dir follows the debounced level

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
btn  input  1  raw asynchronous button level, may bounce
dir  output 1  direction to the counter's x input; registered
btn_db  output 1  debounced button level; registered
press_pulse  output 1  one-cycle pulse on accepted 0->1 transition; registered

Behaviour:
- Reset (rst=0, asynchronous): dir=0, btn_db=0, press_pulse=0, sync flops=0, FSM=IDLE_LO, counter=0.
- Synchroniser: btn passes through two flops (s1, s2). The FSM uses only s2.
- Debounce counter: width is clog2(DB_MAX)+1. It saturates at no point, because it is cleared on any accept or abort.
- FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
  - IDLE_LO: s2=1 -> WAIT_HI, cnt=1. Otherwise stay.
  - WAIT_HI: s2=0 -> IDLE_LO, cnt=0 (abort). If s2=1 and cnt==DB_MAX-1 -> IDLE_HI, cnt=0, btn_db<=1, press_pulse<=1, and dir<=~dir when TOGGLE_MODE=1. Otherwise cnt++.
  - IDLE_HI: s2=0 -> WAIT_LO, cnt=1. Otherwise stay.
  - WAIT_LO: s2=1 -> IDLE_HI, cnt=0 (abort). If s2=0 and cnt==DB_MAX-1 -> IDLE_LO, btn_db<=0. Otherwise cnt++. No pulse is generated on release.
- Latency: the accept registers at rising edge number DB_MAX+2, counting the first edge that samples btn=1 as edge 1. With DB_MAX=4 this is edge 6.
- press_pulse is high for exactly one cycle after an accept. It is cleared on the following edge whatever the state of btn.
- TOGGLE_MODE=0: dir<=btn_db's next value. dir changes on the same edge as btn_db.
- Glitches shorter than DB_MAX cycles at s2 are ignored. Outputs are unchanged.
- Continuous high input produces exactly one pulse and one toggle.
- Bounce restarts the count from the last transition.
- Reset mid-WAIT aborts with no pulse and no dir change. After reset deasserts, an already-high btn is accepted after a full DB_MAX+2 edges.
- Every reachable state has a defined transition. The default branch returns to IDLE_LO with all counters cleared.

Decomposition:
- Shared include updown_defs.vh holds:
  - 2-bit state encodings ST_IDLE_LO=0, ST_WAIT_HI=1, ST_IDLE_HI=2, ST_WAIT_LO=3.
  - The default DB_MAX.
  - The counter's direction convention: x=1 means count up.
- One sub-module, sync_2ff: a two-flop synchroniser with asynchronous active-low reset to 0. It is reused by later input blocks.
- The debounce FSM, counter and output registers stay in updown_dir_ctrl.

Test Plan:
All scenarios use a 10 ns clock, DB_MAX=4 and TOGGLE_MODE=1 unless stated.
1. Hold rst=0 for 10 ns with btn=0, then release -> dir=0, btn_db=0, press_pulse=0 throughout. Also pulse rst low mid-cycle -> outputs clear immediately, asynchronously.
2. Clean press: btn 0->1 and hold 100 ns -> btn_db=1 and dir 0->1 at the 6th rising edge after the rise. press_pulse=1 for exactly one cycle, 0 thereafter.
3. Glitch: btn high for 20 ns, then low -> btn_db, dir and press_pulse all stay 0.
4. Press and release twice, 100 ns each -> dir goes 0->1->0. There are exactly 2 press pulses and 0 pulses on release. btn_db returns to 0 six edges after each fall.
5. Bounce: btn 1,0,1,0 at 10 ns each, then steady 1 -> exactly one press_pulse. It occurs 6 edges after the final 0->1 transition.
6. Assert rst during WAIT_HI (3 edges after btn rise) with btn held 1, then release rst -> no pulse before reset. After release, accept after 6 edges with press_pulse=1 and dir=1. Repeating with TOGGLE_MODE=0 -> dir tracks btn_db on every edge.

Source files
------------

// File: rtl/updown_dir_ctrl_pkg.sv
// Shared definitions for the up/down counter input conditioners:
// debounce FSM state encoding, default debounce length and direction polarity.
package updown_dir_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_LO = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_IDLE_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    localparam int DB_MAX_DEFAULT = 4;

    // The counter counts up when its x input is 1.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_dir_ctrl_sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs; clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/updown_dir_ctrl.sv
// Push-button conditioner feeding the up/down counter's direction input:
// synchronise, debounce, emit a press pulse and derive the direction.
module updown_dir_ctrl
    import updown_dir_ctrl_pkg::*;
#(
    parameter int DB_MAX      = DB_MAX_DEFAULT,
    parameter bit TOGGLE_MODE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic dir,
    output logic btn_db,
    output logic press_pulse
);

    localparam int             CW       = $clog2(DB_MAX) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_MAX - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_dir;
    logic          r_btn_db;
    logic          r_pulse;
    logic          w_dir_nxt;
    logic          w_db_nxt;
    logic          w_pulse_nxt;
    logic          w_s2;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (btn),
        .o_q (w_s2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE_LO;
            r_cnt    <= '0;
            r_dir    <= DIR_DOWN;
            r_btn_db <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dir    <= w_dir_nxt;
            r_btn_db <= w_db_nxt;
            r_pulse  <= w_pulse_nxt;
        end
    end

    // The counter is cleared on every accept or abort, so it never needs to saturate.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_db_nxt    = r_btn_db;
        w_dir_nxt   = r_dir;
        w_pulse_nxt = 1'b0;
        case (r_state)
            ST_IDLE_LO: begin
                if (w_s2) begin
                    w_state_nxt = ST_WAIT_HI;
                    w_cnt_nxt   = CW'(1);
                end
            end
            ST_WAIT_HI: begin
                if (!w_s2) begin
                    w_state_nxt = ST_IDLE_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE_HI;
                    w_cnt_nxt   = '0;
                    w_db_nxt    = 1'b1;
                    w_pulse_nxt = 1'b1;
                    if (TOGGLE_MODE) begin
                        w_dir_nxt = ~r_dir;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_IDLE_HI: begin
                if (!w_s2) begin
                    w_state_nxt = ST_WAIT_LO;
                    w_cnt_nxt   = CW'(1);
                end
            end
            ST_WAIT_LO: begin
                if (w_s2) begin
                    w_state_nxt = ST_IDLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE_LO;
                    w_cnt_nxt   = '0;
                    w_db_nxt    = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE_LO;
                w_cnt_nxt   = '0;
            end
        endcase
        // In level mode the direction simply mirrors the debounced button.
        if (!TOGGLE_MODE) begin
            w_dir_nxt = w_db_nxt;
        end
    end

    assign dir         = r_dir;
    assign btn_db      = r_btn_db;
    assign press_pulse = r_pulse;

endmodule

// File: tb/tb_updown_dir_ctrl.sv
// Bench for updown_dir_ctrl: a toggle-mode and a level-mode instance share one
// button, and both are compared every cycle with a run-length debounce model.
module tb_updown_dir_ctrl;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;

    logic dirT, dbT, ppT;
    logic dirF, dbF, ppF;
    logic [5:0] got;

    int checks   = 0;
    int failures = 0;

    // Model: a new level is accepted once the synchronised button has
    // disagreed with the current level for DB consecutive sampling edges.
    logic m_s1    = 1'b0;
    logic m_s2    = 1'b0;
    logic m_lvl   = 1'b0;
    logic m_dirT  = 1'b0;
    logic m_pulse = 1'b0;
    int   m_run   = 0;

    updown_dir_ctrl #(.DB_MAX(DB), .TOGGLE_MODE(1'b1)) u_dut_tog (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .dir         (dirT),
        .btn_db      (dbT),
        .press_pulse (ppT)
    );

    updown_dir_ctrl #(.DB_MAX(DB), .TOGGLE_MODE(1'b0)) u_dut_lvl (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .dir         (dirF),
        .btn_db      (dbF),
        .press_pulse (ppF)
    );

    assign got = {dirT, dbT, ppT, dirF, dbF, ppF};

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0;
            m_dirT = 1'b0; m_pulse = 1'b0; m_run = 0;
        end else begin
            m_pulse = 1'b0;
            if (m_s2 != m_lvl) begin
                m_run = m_run + 1;
                if (m_run == DB) begin
                    m_lvl = m_s2;
                    m_run = 0;
                    if (m_lvl) begin
                        m_pulse = 1'b1;
                        m_dirT  = ~m_dirT;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    end

    function automatic logic [5:0] exp_vec();
        return {m_dirT, m_lvl, m_pulse, m_lvl, m_lvl, m_pulse};
    endfunction

    // Drive the button for one full cycle, returning at the next falling edge.
    task automatic step(input logic b);
        btn = b;
        @(negedge clk);
    endtask

    task automatic settle(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    task automatic test_reset();
        btn = 1'b0;
        #1 rst = 1'b0;
        #10;
        checks++;
        if (got !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_hold: got %b expected %b", got, 6'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1'b0);
            checks++;
            if (got !== exp_vec() || got !== 6'b0) begin
                failures++;
                $display("[TB] FAIL reset_idle step %0d: got %b expected %b", k, got, 6'b0);
            end
        end
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        int pulse_edge = -1;
        logic dir_exp;
        dir_exp = ~m_dirT;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1);
            checks++;
            if (got !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL clean_press edge %0d: got %b expected %b", k, got, exp_vec());
            end
            if (ppT) begin
                pulses++;
                if (pulse_edge < 0) pulse_edge = k;
            end
        end
        checks++;
        if (pulse_edge != DB + 2) begin
            failures++;
            $display("[TB] FAIL clean_press_latency: got %0d expected %0d", pulse_edge, DB + 2);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("[TB] FAIL clean_press_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (dirT !== dir_exp || dbT !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clean_press_dir: got dir=%b db=%b expected dir=%b db=1", dirT, dbT, dir_exp);
        end
    endtask

    task automatic test_async_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (got !== 6'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: got %b expected %b", got, 6'b0);
        end
        btn = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        settle(1'b0, 4);
    endtask

    task automatic test_glitch();
        int pulses = 0;
        int db_seen = 0;
        settle(1'b0, 8);
        for (int k = 0; k < 10; k++) begin
            step((k < 2) ? 1'b1 : 1'b0);
            checks++;
            if (got !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL glitch step %0d: got %b expected %b", k, got, exp_vec());
            end
            if (ppT) pulses++;
            if (dbT) db_seen++;
        end
        checks++;
        if (pulses != 0 || db_seen != 0) begin
            failures++;
            $display("[TB] FAIL glitch_ignored: got pulses=%0d db_high=%0d expected 0 and 0", pulses, db_seen);
        end
    endtask

    task automatic test_press_release();
        int pulses = 0;
        int fall_edge;
        logic dir_start;
        settle(1'b0, 8);
        dir_start = m_dirT;
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 10; k++) begin
                step(1'b1);
                checks++;
                if (got !== exp_vec()) begin
                    failures++;
                    $display("[TB] FAIL press_release hi r%0d edge %0d: got %b expected %b", r, k, got, exp_vec());
                end
                if (ppT) pulses++;
            end
            checks++;
            if (dirT !== (dir_start ^ ((r % 2) == 0))) begin
                failures++;
                $display("[TB] FAIL press_release_dir r%0d: got %b expected %b", r, dirT, dir_start ^ ((r % 2) == 0));
            end
            fall_edge = -1;
            for (int k = 1; k <= 10; k++) begin
                step(1'b0);
                checks++;
                if (got !== exp_vec()) begin
                    failures++;
                    $display("[TB] FAIL press_release lo r%0d edge %0d: got %b expected %b", r, k, got, exp_vec());
                end
                if (ppT) pulses++;
                if (!dbT && fall_edge < 0) fall_edge = k;
            end
            checks++;
            if (fall_edge != DB + 2) begin
                failures++;
                $display("[TB] FAIL release_latency r%0d: got %0d expected %0d", r, fall_edge, DB + 2);
            end
        end
        checks++;
        if (pulses != 2 || dirT !== dir_start) begin
            failures++;
            $display("[TB] FAIL press_release_total: got pulses=%0d dir=%b expected 2 and %b", pulses, dirT, dir_start);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int pulse_edge = -1;
        logic [3:0] pat;
        settle(1'b0, 8);
        pat = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            step(pat[k]);
            checks++;
            if (got !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL bounce step %0d: got %b expected %b", k, got, exp_vec());
            end
            if (ppT) pulses++;
        end
        for (int k = 1; k <= 10; k++) begin
            step(1'b1);
            checks++;
            if (got !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL bounce steady edge %0d: got %b expected %b", k, got, exp_vec());
            end
            if (ppT) begin
                pulses++;
                if (pulse_edge < 0) pulse_edge = k;
            end
        end
        checks++;
        if (pulses != 1 || pulse_edge != DB + 2) begin
            failures++;
            $display("[TB] FAIL bounce_result: got pulses=%0d edge=%0d expected 1 and %0d", pulses, pulse_edge, DB + 2);
        end
    endtask

    task automatic test_reset_mid_wait();
        int pulses = 0;
        int pulse_edge = -1;
        settle(1'b0, 8);
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            if (ppT) pulses++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (got !== 6'b0 || pulses != 0) begin
            failures++;
            $display("[TB] FAIL reset_mid_wait: got %b pulses=%0d expected %b and 0", got, pulses, 6'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1);
            checks++;
            if (got !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL after_reset edge %0d: got %b expected %b", k, got, exp_vec());
            end
            if (ppT && pulse_edge < 0) pulse_edge = k;
        end
        checks++;
        if (pulse_edge != DB + 2 || dirT !== 1'b1 || dirF !== 1'b1) begin
            failures++;
            $display("[TB] FAIL after_reset_accept: got edge=%0d dirT=%b dirF=%b expected %0d 1 1", pulse_edge, dirT, dirF, DB + 2);
        end
    endtask

    task automatic test_random();
        logic b;
        int len;
        for (int burst = 0; burst < 40; burst++) begin
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                step(b);
                checks++;
                if (got !== exp_vec()) begin
                    failures++;
                    $display("[TB] FAIL random burst %0d: got %b expected %b", burst, got, exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_async_reset();
        test_glitch();
        test_press_release();
        test_bounce();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
